fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the single-cycle-read instruction memory. Owns the fetch PC, drives the memory's byte address, and captures each returned 32-bit word with its PC into a small prefetch FIFO. Presents fetched instructions to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the prefetch state.

## Interface

Parameters:
- `RESET_PC`, default 8'h00: fetch address after reset; low two bits ignored (forced 00).
- `DEPTH`, default 2: prefetch FIFO entries; legal values 2 or 4.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising edge of `clk`.
- `run` input 1: fetch enable; 0 stops new fetches and leaves FIFO contents intact.
- `i_address` output 8: byte address to instruction memory; always equal to the fetch PC.
- `instruction` input 32: combinational memory read data for `i_address`.
- `redirect_valid` input 1: one-cycle redirect request from execute.
- `redirect_pc` input 8: redirect target; low two bits ignored.
- `out_valid` output 1: FIFO head holds a valid instruction.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_instr` output 32: instruction at FIFO head.
- `out_pc` output 8: byte address of `out_instr`.

## Operation

- States: STOPPED (`run`=0) and RUNNING (`run`=1). Transitions follow `run` each cycle. Reset enters STOPPED if `run`=0, else RUNNING.
- Fetch PC (`pc`) is an 8-bit register, always word-aligned: `pc[1:0]`=00.
- Pop: when `out_valid` && `out_ready` && !`redirect_valid`, remove the head.
- Push: in RUNNING, when !`redirect_valid` and (count < DEPTH or pop this cycle):
  - write {`pc`, `instruction`} at the tail;
  - set `pc <= pc + 4` modulo 256, so 8'hFC wraps to 8'h00.
- Full with no pop: no push, `pc` holds, and `i_address` is stable.
- Simultaneous push and pop at full: both occur, and count stays DEPTH.
- Simultaneous push and pop at empty is impossible, because the head is registered; an empty FIFO never asserts `out_valid`.
- Redirect has priority over everything except reset:
  - count is set to 0;
  - `pc <= {redirect_pc[7:2], 2'b00}`;
  - no push and no pop that cycle;
  - a handshake coinciding with redirect is discarded, and decode must treat it as killed.
- Redirect is honoured in STOPPED as well, and updates `pc`.
- `run` deasserting stops pushes only; decode may drain the FIFO.
- FIFO: circular buffer with read/write pointers and a count of width log2(DEPTH)+1.
- `out_instr`/`out_pc` are driven from the head entry register. When the FIFO is empty they are held at 0.
- Count never exceeds DEPTH and never goes below 0. Pointers wrap modulo DEPTH.

## Timing

- Reset values:
  - `pc`=RESET_PC aligned, so `i_address`=RESET_PC & 8'hFC;
  - count=0 and pointers=0;
  - `out_valid`=0, `out_instr`=32'h0, `out_pc`=8'h0.
- Reset mid-operation discards all FIFO entries, ignores any same-cycle redirect, and aborts any same-cycle handshake.
- Fetch latency:
  - address presented in cycle N;
  - entry written at the edge ending cycle N;
  - `out_valid`=1 in cycle N+1.
- First instruction after reset release (with `run`=1): visible one cycle after the first fetch cycle.
- Redirect latency:
  - redirect in cycle N;
  - `i_address`=target in cycle N+1;
  - `out_valid`=0 in cycle N+1;
  - target instruction at head in cycle N+2.
- Sustained throughput is one instruction per cycle when `out_ready`=1 continuously.
- No combinational path from `out_ready` or `redirect_valid` to `out_valid`, `out_instr` or `out_pc`.
- `i_address` depends only on registered `pc`.

## Test plan

- Reset, `run`=1, `out_ready`=1, memory holds 32'h21080003 at 0 and 32'h212900FF at 4:
  - `out_pc`=0x00/`out_instr`=32'h21080003 in cycle 1;
  - `out_pc`=0x04/`out_instr`=32'h212900FF in cycle 2.
- Backpressure: `out_ready`=0 for 5 cycles, DEPTH=2:
  - count saturates at 2;
  - `i_address` freezes at 0x08;
  - releasing `out_ready` delivers PCs 0x00, 0x04, 0x08 in order with no gap or duplicate.
- Redirect to 8'h13 while FIFO holds 2 entries and `out_ready`=1:
  - next cycle `out_valid`=0 and `i_address`=0x10;
  - following cycle `out_pc`=0x10;
  - the same-cycle pop is discarded.
- Wrap: redirect to 0xF8:
  - delivered PCs are 0xF8, 0xFC, 0x00, 0x04.
- `run` dropped with 2 entries buffered:
  - no further `i_address` advance;
  - both entries drain;
  - `out_valid`=0 afterwards;
  - `run`=1 resumes from the held `pc`.
- Reset asserted mid-stream together with `redirect_valid`:
  - next cycle `out_valid`=0 and `i_address`=RESET_PC; the redirect is ignored;
  - a mid-stream reset with RESET_PC=8'h22 gives `i_address`=0x20.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, buffers fetched
// words in a small prefetch FIFO and hands them to decode.
module fetch_sequencer #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic [7:0]  i_address,
   input  logic [31:0] instruction,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [7:0]  out_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [7:0] RST_PC = {RESET_PC[7:2], 2'b00};

   typedef enum logic {STOPPED, RUNNING} state_e;

   state_e        state_q, state_d;
   logic [7:0]    pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic          push, pop;

   logic [31:0]   instr_q [DEPTH];
   logic [7:0]    epc_q   [DEPTH];

   // Alignment bits of the redirect target are deliberately dropped.
   logic unused_bits;
   assign unused_bits = ^redirect_pc[1:0];

   assign i_address = pc_q;
   assign out_valid = (count_q != '0);
   assign out_instr = out_valid ? instr_q[rptr_q] : 32'h0;
   assign out_pc    = out_valid ? epc_q[rptr_q] : 8'h0;

   always_comb begin
      state_d = run ? RUNNING : STOPPED;
      pc_d    = pc_q;
      count_d = count_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      pop     = out_valid && out_ready && !redirect_valid;
      push    = (state_q == RUNNING) && !redirect_valid
                && ((count_q != FULL) || pop);
      if (redirect_valid) begin
         pc_d    = {redirect_pc[7:2], 2'b00};
         count_d = '0;
         rptr_d  = '0;
         wptr_d  = '0;
      end else begin
         if (pop) rptr_d = rptr_q + 1'b1;
         if (push) begin
            wptr_d = wptr_q + 1'b1;
            pc_d   = pc_q + 8'd4;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= run ? RUNNING : STOPPED;
         pc_q    <= RST_PC;
         count_q <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
      end
   end

   // Entry storage needs no reset: the count masks stale slots.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wptr_q] <= instruction;
         epc_q[wptr_q]   <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a queue-based reference model
// predicts deliveries, a negedge monitor compares against the DUT.
module tb_fetch_sequencer;

   localparam logic [7:0] RPC = 8'h22;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b1;
   logic [7:0]  i_address;
   logic [31:0] instruction;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;

   logic [31:0] mem [64];
   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [39:0] exp_q [$];
   logic [7:0]  m_pc;
   bit          m_run;
   bit          started = 0;

   always #5 clk = ~clk;

   assign instruction = mem[i_address[7:2]];

   fetch_sequencer #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .i_address(i_address),
      .instruction(instruction),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
   );

   task automatic chk(input string name, input logic [39:0] act,
                      input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: fetched words queue up in order; a redirect flushes them.
   always @(posedge clk) begin
      bit pop, push;
      if (reset) begin
         exp_q.delete();
         m_pc = RPC & 8'hFC;
         m_run = run;
         started = 1;
      end else if (started) begin
         pop = (exp_q.size() > 0) && out_ready && !redirect_valid;
         if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc & 8'hFC;
         end else begin
            push = m_run && ((exp_q.size() < DEPTH) || pop);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
               exp_q.push_back({m_pc, mem[m_pc[7:2]]});
               m_pc = m_pc + 8'd4;
            end
         end
         m_run = run;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (started) begin
         chk("i_address", {32'h0, i_address}, {32'h0, m_pc});
         chk("out_valid", {39'h0, out_valid},
             {39'h0, exp_q.size() > 0});
         if (exp_q.size() > 0)
            chk("head", {out_pc, out_instr}, exp_q[0]);
         else
            chk("empty_head", {out_pc, out_instr}, 40'h0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [7:0] t);
      redirect_valid = 1'b1;
      redirect_pc = t;
      step(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h21080003;
      mem[1] = 32'h212900FF;

      step(1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_addr", {32'h0, i_address}, {32'h0, 8'h20});
      chk("rst_valid", {39'h0, out_valid}, 40'h0);
      chk("rst_head", {out_pc, out_instr}, 40'h0);

      // First words at 0
      #1;
      redirect(8'h00);
      @(negedge clk);
      chk("redir0_addr", {32'h0, i_address}, 40'h0);
      chk("redir0_valid", {39'h0, out_valid}, 40'h0);
      step(1);
      @(negedge clk);
      chk("word0", {out_pc, out_instr}, {8'h00, 32'h21080003});
      #1;
      step(1);
      @(negedge clk);
      chk("word1", {out_pc, out_instr}, {8'h04, 32'h212900FF});

      // Backpressure
      #1;
      out_ready = 1'b0;
      redirect(8'h00);
      step(4);
      @(negedge clk);
      chk("bp_freeze", {32'h0, i_address}, {32'h0, 8'h08});
      chk("bp_head", {32'h0, out_pc}, 40'h0);
      #1;
      out_ready = 1'b1;
      step(1);
      @(negedge clk);
      chk("bp_rel1", {32'h0, out_pc}, {32'h0, 8'h04});
      #1;
      step(1);
      @(negedge clk);
      chk("bp_rel2", {32'h0, out_pc}, {32'h0, 8'h08});

      // Redirect to 0x13 with a full FIFO and a coincident handshake
      #1;
      out_ready = 1'b0;
      step(3);
      out_ready = 1'b1;
      redirect(8'h13);
      @(negedge clk);
      chk("r13_valid", {39'h0, out_valid}, 40'h0);
      chk("r13_addr", {32'h0, i_address}, {32'h0, 8'h10});
      #1;
      step(1);
      @(negedge clk);
      chk("r13_head", {32'h0, out_pc}, {32'h0, 8'h10});

      // Wrap past 0xFC
      #1;
      redirect(8'hF8);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] e;
         e = 8'hF8 + 8'(4 * i);
         step(1);
         @(negedge clk);
         chk("wrap_pc", {32'h0, out_pc}, {32'h0, e});
         #1;
      end

      // Drop run with entries buffered, drain, resume
      out_ready = 1'b0;
      step(3);
      run = 1'b0;
      step(2);
      out_ready = 1'b1;
      step(4);
      @(negedge clk);
      chk("drained", {39'h0, out_valid}, 40'h0);
      #1;
      run = 1'b1;
      step(4);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         run = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc = 8'($urandom);
         reset = ($urandom_range(0, 49) == 0);
         step(1);
      end
      reset = 1'b0;
      redirect_valid = 1'b0;
      run = 1'b1;
      out_ready = 1'b1;
      step(3);

      // Reset together with redirect mid-stream
      reset = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 8'h40;
      step(1);
      reset = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_addr", {32'h0, i_address}, {32'h0, 8'h20});
      chk("rst_mid_valid", {39'h0, out_valid}, 40'h0);
      #1;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
